// File: rtl/frame_tx_pkg.sv
// Shared constants and types for the measurement frame transmitter.
// Optional checksum byte is selected with the FRAME_TX_CHECKSUM_EN macro.
package frame_tx_pkg;
   localparam logic [7:0] HDR0 = 8'hAA;
   localparam logic [7:0] HDR1 = 8'h55;
`ifdef FRAME_TX_CHECKSUM_EN
   localparam int FRAME_LEN = 11;
`else
   localparam int FRAME_LEN = 10;
`endif
   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
endpackage

// File: rtl/frame_tx_period_tick.sv
// Free-running frame period counter; tick is high for the last count of each period.
module period_tick #(
   parameter int unsigned FRAME_PERIOD = 50_000_000
) (
   input  logic sys_clk,
   input  logic rst,
   output logic tick
);
   localparam logic [31:0] LAST = 32'(FRAME_PERIOD - 1);

   logic [31:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 32'd1;
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/frame_tx.sv
// Snapshots the packed measurement word once per period and streams it as a byte frame.
// Define FRAME_TX_CHECKSUM_EN to append an XOR checksum of the eight data bytes.
module frame_tx
   import frame_tx_pkg::*;
#(
   parameter int unsigned FRAME_PERIOD = 50_000_000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [63:0] data64,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  overrun_cnt
);
   function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [63:0] w,
                                             input logic [7:0] sum);
      case (i)
         4'd0:    frame_byte = HDR0;
         4'd1:    frame_byte = HDR1;
         4'd2:    frame_byte = w[63:56];
         4'd3:    frame_byte = w[55:48];
         4'd4:    frame_byte = w[47:40];
         4'd5:    frame_byte = w[39:32];
         4'd6:    frame_byte = w[31:24];
         4'd7:    frame_byte = w[23:16];
         4'd8:    frame_byte = w[15:8];
         4'd9:    frame_byte = w[7:0];
         default: frame_byte = sum;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic        tick;
   state_t      state;
   logic [63:0] shadow;
   logic [3:0]  idx;
   logic        accept;
   logic [7:0]  csum_nxt;

   period_tick #(.FRAME_PERIOD(FRAME_PERIOD)) u_period_tick (
      .sys_clk (sys_clk),
      .rst     (rst),
      .tick    (tick)
   );

   assign accept = (state == SEND) && tx_valid && tx_ready;

`ifdef FRAME_TX_CHECKSUM_EN
   logic [7:0] csum;

   // tx_data is the byte being accepted, so fold it in before choosing the next byte
   always_comb begin
      csum_nxt = csum;
      if (accept && (idx >= 4'd2) && (idx <= 4'd9))
         csum_nxt = csum ^ tx_data;
   end

   always_ff @(posedge sys_clk) begin
      if (state == LOAD)
         csum <= '0;
      else
         csum <= csum_nxt;
   end
`else
   assign csum_nxt = 8'h00;
`endif

   always_ff @(posedge sys_clk) begin
      if (state == LOAD)
         shadow <= data64;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         frame_done <= 1'b0;
         // Any tick outside IDLE is dropped, including one landing in DONE
         if (tick && (state != IDLE))
            overrun_cnt <= sat_inc(overrun_cnt);
         case (state)
            IDLE: begin
               if (tick) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               idx      <= '0;
               tx_data  <= HDR0;
               tx_valid <= 1'b1;
               state    <= SEND;
            end
            SEND: begin
               if (accept) begin
                  if (idx == LAST_IDX) begin
                     tx_valid   <= 1'b0;
                     tx_data    <= '0;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx     <= idx + 4'd1;
                     tx_data <= frame_byte(idx + 4'd1, shadow, csum_nxt);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: byte order, backpressure, shadowing, overrun and reset abort.
module tb_frame_tx;
`ifdef FRAME_TX_CHECKSUM_EN
   localparam int FLEN = 11;
`else
   localparam int FLEN = 10;
`endif
   localparam int P = 32;
   localparam logic [63:0] WORD = 64'h0012_0034_0000_C350;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] data64 = WORD;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        frame_done;
   logic [7:0]  overrun_cnt;

   logic        rst8 = 1'b1;
   logic [7:0]  tx_data8;
   logic        tx_valid8;
   logic        busy8;
   logic        frame_done8;
   logic [7:0]  overrun_cnt8;

   int total = 0;
   int bad = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   frame_tx #(.FRAME_PERIOD(P)) dut (
      .sys_clk(clk), .rst(rst), .data64(data64), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
   );

   frame_tx #(.FRAME_PERIOD(8)) dut8 (
      .sys_clk(clk), .rst(rst8), .data64(WORD), .tx_data(tx_data8), .tx_valid(tx_valid8),
      .tx_ready(1'b1), .busy(busy8), .frame_done(frame_done8), .overrun_cnt(overrun_cnt8)
   );

   task automatic push_frame(input logic [63:0] w, input logic [7:0] cs);
      sb.push_back(8'hAA);
      sb.push_back(8'h55);
      for (int i = 0; i < 8; i++) sb.push_back(w[63-8*i -: 8]);
      if (FLEN == 11) sb.push_back(cs);
   endtask

   // Waits for the first tx_valid; lat >= 0 also checks busy/tx_valid latency
   task automatic wait_start(input string nm, input int lat, input int budget);
      int cyc = 0;
      int busy_at = -1;
      bit stray_done = 0;
      while (!tx_valid && cyc < budget) begin
         @(negedge clk); #1;
         cyc++;
         if (frame_done) stray_done = 1;
         if (busy && busy_at < 0) busy_at = cyc;
      end
      total++;
      if (!tx_valid) begin
         bad++;
         $display("FAIL %s start timeout: tx_valid=%b after %0d cycles", nm, tx_valid, cyc);
      end
      total++;
      if (stray_done) begin
         bad++;
         $display("FAIL %s stray frame_done: seen=1 required=0", nm);
      end
      if (lat >= 0) begin
         total++;
         if (cyc != lat || busy_at != lat - 1) begin
            bad++;
            $display("FAIL %s latency: valid_at=%0d busy_at=%0d required %0d/%0d",
                     nm, cyc, busy_at, lat, lat - 1);
         end
      end
   endtask

   // Consumes one frame starting at the current cycle, popping the scoreboard on each accept
   task automatic collect(input string nm, input bit bp, input int chg_cyc, input int budget);
      int cyc = 0;
      int first_acc = -1;
      int last_acc = -1;
      bit stalled = 0;
      bit done_seen = 0;
      logic [7:0] held = '0;
      logic [7:0] exp;
      tx_ready = 1'b1;
      while (!done_seen && cyc < budget) begin
         if (stalled) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
               bad++;
               $display("FAIL %s stall hold: valid=%b data=%h required valid=1 data=%h",
                        nm, tx_valid, tx_data, held);
            end
         end
         if (frame_done === 1'b1) begin
            done_seen = 1;
            total++;
            if (sb.size() != 0 || cyc != last_acc + 1 || busy !== 1'b1) begin
               bad++;
               $display("FAIL %s frame_done: at=%0d left=%0d busy=%b required at=%0d left=0 busy=1",
                        nm, cyc, sb.size(), busy, last_acc + 1);
            end
         end
         if (tx_valid && tx_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL %s extra byte: got=%h required none", nm, tx_data);
            end else begin
               exp = sb.pop_front();
               if (tx_data !== exp) begin
                  bad++;
                  $display("FAIL %s byte: got=%h required=%h", nm, tx_data, exp);
               end
            end
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
         stalled = tx_valid && !tx_ready;
         held = tx_data;
         if (cyc == chg_cyc) data64 = 64'hFFFF_FFFF_FFFF_FFFF;
         @(negedge clk);
         cyc++;
         tx_ready = bp ? (cyc % 3 == 0) : 1'b1;
         #1;
      end
      total++;
      if (!done_seen) begin
         bad++;
         $display("FAIL %s done timeout: frame_done=0 after %0d cycles", nm, cyc);
      end
      if (!bp) begin
         total++;
         if (last_acc - first_acc != FLEN - 1) begin
            bad++;
            $display("FAIL %s back_to_back: span=%0d required=%0d", nm, last_acc - first_acc, FLEN - 1);
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_fall: busy=%b required=0", nm, busy);
      end
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 ||
          frame_done !== 1'b0 || overrun_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset values: data=%h valid=%b busy=%b done=%b ovr=%h required all 0",
                  tx_data, tx_valid, busy, frame_done, overrun_cnt);
      end
   endtask

   task automatic test_basic();
      push_frame(WORD, 8'hB5);
      tx_ready = 1'b1;
      wait_start("basic", P + 1, 2 * P);
      collect("basic", 1'b0, -1, 40);
   endtask

   task automatic test_backpressure();
      push_frame(WORD, 8'hB5);
      wait_start("bp", -1, 3 * P);
      collect("bp", 1'b1, -1, 80);
   endtask

   task automatic test_shadow();
      push_frame(WORD, 8'hB5);
      wait_start("shadow", -1, 3 * P);
      collect("shadow", 1'b0, 4, 40);
      push_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      wait_start("ff", -1, 3 * P);
      collect("ff", 1'b0, -1, 40);
      data64 = WORD;
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      sb.delete();
      push_frame(WORD, 8'hB5);
      tx_ready = 1'b1;
      wait_start("mid", -1, 3 * P);
      for (int i = 0; i < 6; i++) begin
         exp = sb.pop_front();
         total++;
         if (tx_data !== exp || tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid pre_reset byte%0d: got=%h valid=%b required=%h valid=1",
                     i, tx_data, tx_valid, exp);
         end
         if (i < 5) begin
            @(negedge clk); #1;
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'h00 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL mid abort: valid=%b busy=%b ovr=%h done=%b required 0 0 00 0",
                  tx_valid, busy, overrun_cnt, frame_done);
      end
      sb.delete();
      push_frame(WORD, 8'hB5);
      wait_start("mid_restart", P + 1, 2 * P);
      collect("mid_restart", 1'b0, -1, 40);
   endtask

   task automatic test_overrun();
      logic [7:0] exp;
      rst8 = 1'b1;
      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      for (int c = 1; c <= 9600; c++) begin
         @(negedge clk); #1;
         if (c == 160 || c == 4064 || c == 4079 || c == 4080 || c == 9600) begin
            exp = (c / 16 > 255) ? 8'd255 : 8'(c / 16);
            total++;
            if (overrun_cnt8 !== exp) begin
               bad++;
               $display("FAIL overrun at cycle %0d: got=%0d required=%0d", c, overrun_cnt8, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_shadow();
      test_reset_mid();
      test_overrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
